// File: rtl/rggen_bridge_pkg.sv
// Shared definitions for the APB-to-register bridge: FSM state encodings,
// byte-lane widths and the strobe-to-bit-mask expansion helper.
package rggen_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_RESPOND = 2'b10
    } bridge_state_e;

    localparam int BYTE_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH;

    // Each strobe bit enables one full byte lane of the write mask.
    function automatic logic [DATA_WIDTH-1:0] expand_strobe(input logic [STRB_WIDTH-1:0] strb);
        logic [DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            mask[b*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rggen_bridge_read_mux.sv
// Selects one register's read data from the flattened read-data bus.
// An index beyond the last register yields all zeros.
module rggen_bridge_read_mux
    import rggen_bridge_pkg::*;
#(
    parameter int BUS_WIDTH   = DATA_WIDTH,
    parameter int REGISTERS   = 4,
    parameter int INDEX_WIDTH = 6
) (
    input  logic [INDEX_WIDTH-1:0]         i_index,
    input  logic [REGISTERS*BUS_WIDTH-1:0] i_read_data,
    output logic [BUS_WIDTH-1:0]           o_read_data
);

    // Priority-free select: at most one k can match the index.
    always_comb begin
        o_read_data = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (32'(i_index) == 32'(k)) begin
                o_read_data = i_read_data[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rggen_apb_register_bridge.sv
// APB slave that turns each transfer into a single-cycle register strobe.
// Every transfer takes IDLE -> ACCESS -> RESPOND, i.e. two wait states.
// Optional feature: define RGGEN_APB_BRIDGE_SLVERR_EN to report PSLVERR
// for unmapped addresses and for writes with an all-zero strobe.
//
// Handshake: a transfer is accepted in IDLE when psel & penable are both
// sampled high; o_register_valid is a one-cycle pulse the register consumes
// at the end of ACCESS; o_pready is a one-cycle pulse in RESPOND and the
// master is expected to hold psel until it sees it.
module rggen_apb_register_bridge
    import rggen_bridge_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int REGISTERS     = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
    input  logic                           i_pwrite,
    input  logic [BUS_WIDTH-1:0]           i_pwdata,
    input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
    output logic                           o_pready,
    output logic [BUS_WIDTH-1:0]           o_prdata,
    output logic                           o_pslverr,
    output logic [REGISTERS-1:0]           o_register_valid,
    output logic [BUS_WIDTH-1:0]           o_register_read_mask,
    output logic [BUS_WIDTH-1:0]           o_register_write_mask,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    input  logic [REGISTERS*BUS_WIDTH-1:0] i_register_read_data,
    output logic [1:0]                     o_debug_state
);

    localparam int INDEX_WIDTH = ADDRESS_WIDTH - 2;

    bridge_state_e          state;
    logic [INDEX_WIDTH-1:0] index_q;
    logic                   write_q;

    logic [INDEX_WIDTH-1:0] req_index;
    logic                   req_mapped;
    logic                   req_valid_en;
    logic [REGISTERS-1:0]   req_valid;
    logic [BUS_WIDTH-1:0]   req_write_mask;
    logic [BUS_WIDTH-1:0]   mux_data;
    logic [1:0]             unused_byte_offset;

    // Byte offset within a word carries no meaning for word registers.
    assign unused_byte_offset = i_paddr[1:0];
    assign req_index          = i_paddr[ADDRESS_WIDTH-1:2];
    assign req_mapped         = 32'(req_index) < 32'(REGISTERS);
    assign req_write_mask     = expand_strobe(i_pstrb);

`ifdef RGGEN_APB_BRIDGE_SLVERR_EN
    logic req_error;
    logic error_q;
    // A write that enables no byte lane is rejected rather than forwarded.
    assign req_valid_en = req_mapped && !(i_pwrite && (i_pstrb == '0));
    assign req_error    = !req_mapped || (i_pwrite && (i_pstrb == '0));
`else
    assign req_valid_en = req_mapped;
    assign o_pslverr    = 1'b0;
`endif

    assign req_valid     = req_valid_en ? (REGISTERS'(1) << req_index) : '0;
    assign o_debug_state = state;

    rggen_bridge_read_mux #(
        .BUS_WIDTH   (BUS_WIDTH),
        .REGISTERS   (REGISTERS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_read_mux (
        .i_index     (index_q),
        .i_read_data (i_register_read_data),
        .o_read_data (mux_data)
    );

    // Transfer FSM; every register-side and APB-side output is a flop here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                 <= ST_IDLE;
            index_q               <= '0;
            write_q               <= 1'b0;
            o_pready              <= 1'b0;
            o_prdata              <= '0;
            o_register_valid      <= '0;
            o_register_read_mask  <= '0;
            o_register_write_mask <= '0;
            o_register_write_data <= '0;
`ifdef RGGEN_APB_BRIDGE_SLVERR_EN
            o_pslverr             <= 1'b0;
            error_q               <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_psel && i_penable) begin
                        state                 <= ST_ACCESS;
                        index_q               <= req_index;
                        write_q               <= i_pwrite;
                        o_register_valid      <= req_valid;
                        o_register_read_mask  <= i_pwrite ? '0 : '1;
                        o_register_write_mask <= i_pwrite ? req_write_mask : '0;
                        o_register_write_data <= i_pwrite ? i_pwdata : '0;
`ifdef RGGEN_APB_BRIDGE_SLVERR_EN
                        error_q               <= req_error;
`endif
                    end
                end
                ST_ACCESS: begin
                    o_register_valid      <= '0;
                    o_register_read_mask  <= '0;
                    o_register_write_mask <= '0;
                    o_register_write_data <= '0;
                    if (!i_psel) begin
                        state <= ST_IDLE;
                    end else begin
                        // Capture at the same edge the register sees valid,
                        // so clear-on-read effects land after the sample.
                        state    <= ST_RESPOND;
                        o_pready <= 1'b1;
                        o_prdata <= write_q ? '0 : mux_data;
`ifdef RGGEN_APB_BRIDGE_SLVERR_EN
                        o_pslverr <= error_q;
`endif
                    end
                end
                ST_RESPOND: begin
                    state    <= ST_IDLE;
                    o_pready <= 1'b0;
                    o_prdata <= '0;
`ifdef RGGEN_APB_BRIDGE_SLVERR_EN
                    o_pslverr <= 1'b0;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_apb_register_bridge.sv
// Directed bench for rggen_apb_register_bridge with a small register model
// (register 2 is clear-on-read) and hand-computed expected values.
module tb_rggen_apb_register_bridge;

    localparam int AW = 8;
    localparam int BW = 32;
    localparam int NR = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [BW-1:0]     pwdata;
    logic [BW/8-1:0]   pstrb;
    logic              pready, pslverr;
    logic [BW-1:0]     prdata;
    logic [NR-1:0]     valid;
    logic [BW-1:0]     rmask, wmask, wdata;
    logic [NR*BW-1:0]  rd_flat;
    logic [1:0]        dbg_state;

    rggen_apb_register_bridge #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .REGISTERS     (NR)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_psel                (psel),
        .i_penable             (penable),
        .i_paddr               (paddr),
        .i_pwrite              (pwrite),
        .i_pwdata              (pwdata),
        .i_pstrb               (pstrb),
        .o_pready              (pready),
        .o_prdata              (prdata),
        .o_pslverr             (pslverr),
        .o_register_valid      (valid),
        .o_register_read_mask  (rmask),
        .o_register_write_mask (wmask),
        .o_register_write_data (wdata),
        .i_register_read_data  (rd_flat),
        .o_debug_state         (dbg_state)
    );

    // ---------------- register model ----------------
    logic [31:0] regs [NR];

    always_comb begin
        rd_flat = '0;
        for (int k = 0; k < NR; k++) rd_flat[k*BW +: BW] = regs[k];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs[0] <= 32'h1111_1111;
            regs[1] <= 32'h2222_2222;
            regs[2] <= 32'h1234_5678;
            regs[3] <= 32'h4444_4444;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (valid[k]) begin
                    if (wmask != '0) regs[k] <= (regs[k] & ~wmask) | (wdata & wmask);
                    if (k == 2 && rmask == '1) regs[k] <= '0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int          valid_cnt = 0;
    int          pready_cnt = 0;
    logic [3:0]  valid_log[$];
    int          valid_cyc[$];
    logic [31:0] acc_rmask, acc_wmask, acc_wdata;

    always @(negedge clk) begin
        if (valid != '0) begin
            valid_cnt++;
            valid_log.push_back(valid);
            valid_cyc.push_back(cyc);
        end
        if (dbg_state == 2'b01) begin
            acc_rmask = rmask;
            acc_wmask = wmask;
            acc_wdata = wdata;
        end
        if (pready) pready_cnt++;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        valid_cnt  = 0;
        pready_cnt = 0;
        valid_log.delete();
        valid_cyc.delete();
        acc_rmask = '0;
        acc_wmask = '0;
        acc_wdata = '0;
    endtask

    task automatic apb_idle();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after pready's edge.
    task automatic xfer(input logic [7:0] addr, input logic wr, input logic [31:0] data,
                        input logic [3:0] strb, input logic setup,
                        output logic [31:0] rdata, output logic err, output int waits);
        paddr  = addr;
        pwrite = wr;
        pwdata = data;
        pstrb  = strb;
        psel   = 1'b1;
        if (setup) begin
            penable = 1'b0;
            @(negedge clk);
        end
        penable = 1'b1;
        waits = 0;
        while (!pready && waits < 8) begin
            waits++;
            @(negedge clk);
        end
        if (!pready) check32("pready_timeout", 32'(pready), 32'd1);
        rdata = prdata;
        err   = pslverr;
        @(negedge clk);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        int          w;
        exp_q.push_back(exp);
        xfer(addr, 1'b0, 32'h0, 4'h0, 1'b1, r, e, w);
        apb_idle();
        check32(tag, r, exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic        exp_slverr;
    logic [3:0]  exp_zero_valid;
    int          exp_zero_cnt;

    initial begin
`ifdef RGGEN_APB_BRIDGE_SLVERR_EN
        exp_slverr     = 1'b1;
        exp_zero_valid = 4'b0000;
        exp_zero_cnt   = 0;
`else
        exp_slverr     = 1'b0;
        exp_zero_valid = 4'b0001;
        exp_zero_cnt   = 1;
`endif
        apb_idle();
        paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check32("rst_state",   32'(dbg_state), 32'd0);
        check32("rst_pready",  32'(pready), 32'd0);
        check32("rst_prdata",  prdata, 32'h0);
        check32("rst_valid",   32'(valid), 32'd0);
        check32("rst_wmask",   wmask, 32'h0);
        check32("rst_rmask",   rmask, 32'h0);
        check32("rst_pslverr", 32'(pslverr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Partial-strobe write to register 1
        clear_mon();
        xfer(8'h04, 1'b1, 32'hA5A5_5A5A, 4'b0011, 1'b1, rdata, err, waits);
        apb_idle();
        check32("wr04_waits",  32'(waits), 32'd2);
        check32("wr04_vcnt",   32'(valid_cnt), 32'd1);
        check32("wr04_valid",  32'(valid_log[0]), 32'h2);
        check32("wr04_wmask",  acc_wmask, 32'h0000_FFFF);
        check32("wr04_rmask",  acc_rmask, 32'h0);
        check32("wr04_wdata",  acc_wdata, 32'hA5A5_5A5A);
        check32("wr04_prdata", rdata, 32'h0);
        check32("wr04_slverr", 32'(err), 32'd0);

        // Read back the merged value
        clear_mon();
        rd_check("rd04_data", 8'h04, 32'h2222_5A5A);
        check32("rd04_rmask", acc_rmask, 32'hFFFF_FFFF);
        check32("rd04_wmask", acc_wmask, 32'h0);

        // Clear-on-read register 2: first read sees data, second sees 0
        rd_check("rd08_first",  8'h08, 32'h1234_5678);
        rd_check("rd08_second", 8'h08, 32'h0000_0000);

        // Unmapped read
        clear_mon();
        xfer(8'h10, 1'b0, 32'h0, 4'h0, 1'b1, rdata, err, waits);
        apb_idle();
        check32("rd10_vcnt",   32'(valid_cnt), 32'd0);
        check32("rd10_prdata", rdata, 32'h0);
        check32("rd10_slverr", 32'(err), 32'(exp_slverr));
        check32("rd10_waits",  32'(waits), 32'd2);

        // Byte offset bits are ignored: 0x0F addresses register 3
        rd_check("rd0f_data", 8'h0F, 32'h4444_4444);

        // Write with all strobes low
        clear_mon();
        xfer(8'h00, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b1, rdata, err, waits);
        apb_idle();
        check32("wrz_vcnt",   32'(valid_cnt), 32'(exp_zero_cnt));
        check32("wrz_wmask",  acc_wmask, 32'h0);
        check32("wrz_slverr", 32'(err), 32'(exp_slverr));
        if (exp_zero_cnt == 1) check32("wrz_valid", 32'(valid_log[0]), 32'(exp_zero_valid));
        rd_check("wrz_reg0", 8'h00, 32'h1111_1111);

        // Reset asserted during ACCESS
        clear_mon();
        paddr = 8'h04; pwrite = 1'b1; pwdata = 32'h5555_5555; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check32("rsta_state", 32'(dbg_state), 32'd1);
        check32("rsta_valid", 32'(valid), 32'h2);
        #1 rst_n = 1'b0;
        apb_idle();
        #1;
        check32("rsta_valid0",  32'(valid), 32'd0);
        check32("rsta_wmask0",  wmask, 32'h0);
        check32("rsta_wdata0",  wdata, 32'h0);
        check32("rsta_state0",  32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check32("rsta_nopready", 32'(pready_cnt), 32'd0);

        // Back-to-back writes without an idle setup cycle between them
        clear_mon();
        xfer(8'h00, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b1, rdata, err, waits);
        xfer(8'h0C, 1'b1, 32'hCAFE_F00D, 4'b1100, 1'b0, rdata, err, waits);
        apb_idle();
        @(negedge clk);
        check32("b2b_vcnt",  32'(valid_cnt), 32'd2);
        check32("b2b_pcnt",  32'(pready_cnt), 32'd2);
        if (valid_cnt == 2) begin
            check32("b2b_valid0", 32'(valid_log[0]), 32'h1);
            check32("b2b_valid1", 32'(valid_log[1]), 32'h8);
            check32("b2b_gap",    32'(valid_cyc[1] - valid_cyc[0]), 32'd3);
        end
        rd_check("b2b_reg0", 8'h00, 32'hDEAD_BEEF);
        rd_check("b2b_reg3", 8'h0C, 32'hCAFE_4444);

        // psel dropped during ACCESS
        clear_mon();
        paddr = 8'h04; pwrite = 1'b0; pstrb = 4'h0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check32("drop_access", 32'(dbg_state), 32'd1);
        apb_idle();
        @(negedge clk);
        check32("drop_idle", 32'(dbg_state), 32'd0);
        repeat (3) @(negedge clk);
        check32("drop_nopready", 32'(pready_cnt), 32'd0);
        rd_check("drop_next", 8'h04, 32'h2222_2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
